layer_train_sequencer: RTL and testbench

//  Upstream driver for the 8-neuron learning layer. Buffers (input, target) samples from a valid/ready

---
 rtl/layer_train_sequencer_pkg.sv | 24 ++
 rtl/layer_train_sequencer_if.sv | 37 +++
 rtl/layer_train_sequencer_sample_fifo.sv | 62 ++++++
 rtl/layer_train_sequencer.sv | 149 ++++++++++++++
 tb/tb_layer_train_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_train_sequencer_pkg.sv
// Shared types and defaults for the layer training sequencer.
package layer_train_sequencer_pkg;

  localparam int unsigned Z2O_W  = 8;
  localparam int unsigned FRAC_W = 16;

  typedef logic [Z2O_W-1:0]         zero2one_t;
  typedef logic signed [FRAC_W-1:0] frac_t;

  localparam int unsigned N_DEF      = 16;
  localparam int unsigned M_DEF      = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    FIRE,
    WAIT,
    CAPTURE,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/layer_train_sequencer_if.sv
// Sample stream, layer drive/return and result stream of the training sequencer.
interface layer_train_sequencer_if
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF
) ();

  logic                  s_valid;
  logic                  s_ready;
  zero2one_t [N-1:0]     s_in;
  zero2one_t [M-1:0]     s_target;
  logic                  learn_en;
  zero2one_t [N-1:0]     layer_in;
  zero2one_t [M-1:0]     layer_expected;
  logic                  layer_valid;
  logic                  layer_learn;
  zero2one_t [M-1:0]     layer_out;
  logic                  r_valid;
  logic                  r_ready;
  zero2one_t [M-1:0]     r_out;
  logic                  r_learned;
  logic                  busy;

  modport slave (
    input  s_valid, s_in, s_target, learn_en, layer_out, r_ready,
    output s_ready, layer_in, layer_expected, layer_valid, layer_learn,
           r_valid, r_out, r_learned, busy
  );

  modport master (
    output s_valid, s_in, s_target, learn_en, layer_out, r_ready,
    input  s_ready, layer_in, layer_expected, layer_valid, layer_learn,
           r_valid, r_out, r_learned, busy
  );

endinterface

// File: rtl/layer_train_sequencer_sample_fifo.sv
// Circular sample queue; ready is derived from the registered count only.
module layer_train_sequencer_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       ready_c,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] count_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign ready_c     = (count_q < CW'(DEPTH));
  assign push_ok     = push && ready_c;
  assign pop_ok      = pop && (count_q != '0);
  assign rd_data_c   = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign count_nxt_c = count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/layer_train_sequencer.sv
// Queues (input, target) samples, runs each through the layer one at a time
// and returns the captured layer outputs on a result stream.
module layer_train_sequencer
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned M      = M_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  layer_train_sequencer_if.slave bus
);

  localparam int unsigned SMP_W = (N + M) * Z2O_W;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              learn_q, learn_d;
  zero2one_t [N-1:0] layer_in_q, layer_in_d;
  zero2one_t [M-1:0] layer_exp_q, layer_exp_d;
  logic              layer_valid_q, layer_valid_d;
  logic              layer_learn_q, layer_learn_d;
  logic              r_valid_q, r_valid_d;
  zero2one_t [M-1:0] r_out_q, r_out_d;
  logic              r_learned_q, r_learned_d;
  logic              busy_q, busy_d;

  logic              fifo_ready_c;
  logic              push, pop;
  logic [SMP_W-1:0]  head_c;
  zero2one_t [N-1:0] head_in_c;
  zero2one_t [M-1:0] head_tgt_c;
  logic [CW-1:0]     fifo_count, fifo_count_nxt_c;

  assign push = bus.s_valid && fifo_ready_c;
  assign pop  = (state_q == DISPATCH);
  assign {head_in_c, head_tgt_c} = head_c;

  layer_train_sequencer_sample_fifo #(
    .WIDTH (SMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .wr_data     ({bus.s_in, bus.s_target}),
    .pop         (pop),
    .rd_data_c   (head_c),
    .ready_c     (fifo_ready_c),
    .count       (fifo_count),
    .count_nxt_c (fifo_count_nxt_c)
  );

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    learn_d       = learn_q;
    layer_in_d    = layer_in_q;
    layer_exp_d   = layer_exp_q;
    layer_valid_d = 1'b0;
    layer_learn_d = 1'b0;
    r_valid_d     = r_valid_q;
    r_out_d       = r_out_q;
    r_learned_d   = r_learned_q;

    unique case (state_q)
      IDLE: begin
        if ((fifo_count != '0) && !r_valid_q) state_d = DISPATCH;
      end
      DISPATCH: begin
        layer_in_d    = head_in_c;
        layer_exp_d   = head_tgt_c;
        learn_d       = bus.learn_en;
        cnt_d         = CNT_W'(SETTLE);
        layer_valid_d = 1'b1;
        state_d       = FIRE;
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          r_out_d       = bus.layer_out;
          r_valid_d     = 1'b1;
          r_learned_d   = learn_q;
          layer_learn_d = learn_q;
          state_d       = CAPTURE;
        end
      end
      // r_valid is already visible here, so a ready consumer completes the handshake now.
      CAPTURE, HOLD: begin
        if (bus.r_ready) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (fifo_count_nxt_c != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      learn_q       <= 1'b0;
      layer_in_q    <= '0;
      layer_exp_q   <= '0;
      layer_valid_q <= 1'b0;
      layer_learn_q <= 1'b0;
      r_valid_q     <= 1'b0;
      r_out_q       <= '0;
      r_learned_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      learn_q       <= learn_d;
      layer_in_q    <= layer_in_d;
      layer_exp_q   <= layer_exp_d;
      layer_valid_q <= layer_valid_d;
      layer_learn_q <= layer_learn_d;
      r_valid_q     <= r_valid_d;
      r_out_q       <= r_out_d;
      r_learned_q   <= r_learned_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.s_ready        = fifo_ready_c;
  assign bus.layer_in       = layer_in_q;
  assign bus.layer_expected = layer_exp_q;
  assign bus.layer_valid    = layer_valid_q;
  assign bus.layer_learn    = layer_learn_q;
  assign bus.r_valid        = r_valid_q;
  assign bus.r_out          = r_out_q;
  assign bus.r_learned      = r_learned_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Directed bench for layer_train_sequencer with a combinational stand-in for the layer.
module tb_layer_train_sequencer;
  import layer_train_sequencer_pkg::*;

  localparam int unsigned N      = 16;
  localparam int unsigned M      = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;

  typedef zero2one_t [N-1:0] vin_t;
  typedef zero2one_t [M-1:0] vout_t;

  logic  clock;
  logic  reset;
  int    checks   = 0;
  int    passed   = 0;
  int    lv_cnt   = 0;
  int    ll_cnt   = 0;
  int    both_cnt = 0;
  vout_t res_q[$];
  bit    res_l_q[$];

  layer_train_sequencer_if #(.N(N), .M(M)) bus ();

  layer_train_sequencer #(
    .N(N), .M(M), .DEPTH(DEPTH), .SETTLE(SETTLE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vin_t mk_in(input int k);
    vin_t v;
    for (int i = 0; i < N; i++) v[i] = zero2one_t'((k * 16 + i * 3) & 255);
    return v;
  endfunction

  function automatic vout_t mk_tgt(input int k);
    vout_t v;
    for (int j = 0; j < M; j++) v[j] = zero2one_t'((160 + k * 5 + j) & 255);
    return v;
  endfunction

  // Stand-in layer: out[j] = in[j] ^ in[j+M] ^ expected[j]
  function automatic vout_t layer_fn(input vin_t x, input vout_t e);
    vout_t o;
    for (int j = 0; j < M; j++) o[j] = x[j] ^ x[j + M] ^ e[j];
    return o;
  endfunction

  assign bus.layer_out = layer_fn(bus.layer_in, bus.layer_expected);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.layer_valid === 1'b1) lv_cnt++;
    if (bus.layer_learn === 1'b1) ll_cnt++;
    if (bus.layer_valid === 1'b1 && bus.layer_learn === 1'b1) both_cnt++;
    if (reset === 1'b0 && bus.r_valid === 1'b1 && bus.r_ready === 1'b1) begin
      res_q.push_back(bus.r_out);
      res_l_q.push_back(bus.r_learned);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.r_valid !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.s_valid  = 1'b1;
    bus.s_in     = mk_in(99);
    bus.s_target = mk_tgt(99);
    bus.learn_en = 1'b1;
    bus.r_ready  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.s_ready, bus.r_valid, bus.layer_valid, bus.layer_learn} !== 4'b1000)
        $display("FAIL reset_outputs cyc%0d: got %b want 1000", c,
                 {bus.s_ready, bus.r_valid, bus.layer_valid, bus.layer_learn});
      else passed++;
    end
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else passed++;
    checks++;
    if (bus.layer_in !== '0 || bus.layer_expected !== '0)
      $display("FAIL reset_layer_regs: got %h/%h want 0", bus.layer_in, bus.layer_expected);
    else passed++;
    checks++;
    if (bus.r_out !== '0 || bus.r_learned !== 1'b0)
      $display("FAIL reset_result: got %h/%b want 0/0", bus.r_out, bus.r_learned);
    else passed++;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (lv_cnt !== 0 || ll_cnt !== 0 || bus.busy !== 1'b0)
      $display("FAIL reset_fifo_empty: valid=%0d learn=%0d busy=%b want 0/0/0",
               lv_cnt, ll_cnt, bus.busy);
    else passed++;
  endtask

  task automatic test_single(input int k, input bit learn);
    int    lv0 = lv_cnt;
    int    ll0 = ll_cnt;
    vout_t exp_out = layer_fn(mk_in(k), mk_tgt(k));
    logic [3:0] obs, want;
    res_q.delete();
    res_l_q.delete();
    bus.learn_en = learn;
    bus.r_ready  = 1'b1;
    bus.s_valid  = 1'b1;
    bus.s_in     = mk_in(k);
    bus.s_target = mk_tgt(k);
    tick();
    bus.s_valid  = 1'b0;
    bus.s_in     = '0;
    bus.s_target = '0;
    for (int c = 1; c <= 9; c++) begin
      obs  = {bus.layer_valid, bus.layer_learn, bus.r_valid, bus.busy};
      want = {c == 3, learn && (c == 6), c == 6, c <= 6};
      checks++;
      if (obs !== want)
        $display("FAIL single%0d_timing cyc%0d: valid/learn/rvalid/busy got %b want %b",
                 k, c, obs, want);
      else passed++;
      if (c >= 3 && c <= 6) begin
        checks++;
        if (bus.layer_in !== mk_in(k) || bus.layer_expected !== mk_tgt(k))
          $display("FAIL single%0d_layer_hold cyc%0d: got %h want %h", k, c,
                   bus.layer_in, mk_in(k));
        else passed++;
      end
      if (c == 6) begin
        checks++;
        if (bus.r_out !== exp_out || bus.r_learned !== learn)
          $display("FAIL single%0d_result: got %h/%b want %h/%b", k,
                   bus.r_out, bus.r_learned, exp_out, learn);
        else passed++;
        if (k == 1) begin
          checks++;
          if (bus.r_out[0] !== 8'h9D)
            $display("FAIL single1_rout0: got %h want 9d", bus.r_out[0]);
          else passed++;
        end
      end
      tick();
    end
    checks++;
    if (res_q.size() != 1 || lv_cnt - lv0 != 1 || ll_cnt - ll0 != int'(learn))
      $display("FAIL single%0d_counts: results=%0d valids=%0d learns=%0d want 1/1/%0d",
               k, res_q.size(), lv_cnt - lv0, ll_cnt - ll0, learn);
    else passed++;
  endtask

  task automatic test_fill();
    int    lv0 = lv_cnt;
    int    n;
    bit    ok;
    vout_t want;
    res_q.delete();
    res_l_q.delete();
    bus.learn_en = 1'b1;
    bus.r_ready  = 1'b0;
    for (int p = 0; p < 5; p++) begin
      bus.s_valid  = 1'b1;
      bus.s_in     = mk_in(10 + p);
      bus.s_target = mk_tgt(10 + p);
      checks++;
      if (bus.s_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", p, bus.s_ready);
      else passed++;
      tick();
    end
    bus.s_in     = mk_in(15);
    bus.s_target = mk_tgt(15);
    checks++;
    if (bus.s_ready !== 1'b0 || lv_cnt - lv0 != 1)
      $display("FAIL fill_full: s_ready=%b dispatched=%0d want 0/1", bus.s_ready, lv_cnt - lv0);
    else passed++;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (bus.s_ready !== 1'b0 || bus.r_valid !== 1'b1 || lv_cnt - lv0 != 1)
      $display("FAIL fill_stall: s_ready=%b r_valid=%b dispatched=%0d want 0/1/1",
               bus.s_ready, bus.r_valid, lv_cnt - lv0);
    else passed++;
    bus.r_ready = 1'b1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) $display("FAIL fill_accept6: s_ready got %b want 1 within 40", bus.s_ready);
    else passed++;
    tick();
    bus.s_valid = 1'b0;
    wait_idle(200, ok);
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (!ok || res_q.size() != 6)
      $display("FAIL fill_count: idle=%b results=%0d want 1/6", ok, res_q.size());
    else passed++;
    for (int i = 0; i < 6; i++) begin
      want = layer_fn(mk_in(10 + i), mk_tgt(10 + i));
      checks++;
      if (i >= res_q.size()) $display("FAIL fill_order%0d: got none want %h", i, want);
      else if (res_q[i] !== want || res_l_q[i] !== 1'b1)
        $display("FAIL fill_order%0d: got %h/%b want %h/1", i, res_q[i], res_l_q[i], want);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int    lv0 = lv_cnt;
    int    n;
    bit    ok;
    vout_t w0 = layer_fn(mk_in(20), mk_tgt(20));
    vout_t w1 = layer_fn(mk_in(21), mk_tgt(21));
    res_q.delete();
    res_l_q.delete();
    bus.learn_en = 1'b1;
    bus.r_ready  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus.s_valid  = 1'b1;
      bus.s_in     = mk_in(20 + p);
      bus.s_target = mk_tgt(20 + p);
      tick();
    end
    bus.s_valid = 1'b0;
    n = 0;
    while (bus.r_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 30) $display("FAIL bp_rvalid: got %b want 1 within 30", bus.r_valid);
    else passed++;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.r_valid !== 1'b1 || bus.r_out !== w0 || bus.r_learned !== 1'b1)
        $display("FAIL bp_hold cyc%0d: got %b/%h/%b want 1/%h/1", c,
                 bus.r_valid, bus.r_out, bus.r_learned, w0);
      else passed++;
      tick();
    end
    checks++;
    if (lv_cnt - lv0 != 1) $display("FAIL bp_no_fire: dispatched %0d want 1", lv_cnt - lv0);
    else passed++;
    bus.r_ready = 1'b1;
    wait_idle(100, ok);
    checks++;
    if (!ok || res_q.size() != 2 || lv_cnt - lv0 != 2)
      $display("FAIL bp_drain: idle=%b results=%0d dispatched=%0d want 1/2/2",
               ok, res_q.size(), lv_cnt - lv0);
    else passed++;
    checks++;
    if (res_q.size() < 2) $display("FAIL bp_order: got %0d results want 2", res_q.size());
    else if (res_q[0] !== w0 || res_q[1] !== w1)
      $display("FAIL bp_order: got %h,%h want %h,%h", res_q[0], res_q[1], w0, w1);
    else passed++;
  endtask

  task automatic test_reset_wait();
    int lv0 = lv_cnt;
    int ll0;
    res_q.delete();
    res_l_q.delete();
    bus.learn_en = 1'b1;
    bus.r_ready  = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.s_valid  = 1'b1;
      bus.s_in     = mk_in(30 + p);
      bus.s_target = mk_tgt(30 + p);
      tick();
    end
    bus.s_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (lv_cnt - lv0 != 1 || bus.r_valid !== 1'b0)
      $display("FAIL rw_in_wait: dispatched=%0d r_valid=%b want 1/0", lv_cnt - lv0, bus.r_valid);
    else passed++;
    ll0   = ll_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.layer_learn, bus.r_valid, bus.layer_valid, bus.busy} !== 4'b0000)
        $display("FAIL rw_after cyc%0d: learn/rvalid/valid/busy got %b want 0000", c,
                 {bus.layer_learn, bus.r_valid, bus.layer_valid, bus.busy});
      else passed++;
      tick();
    end
    checks++;
    if (ll_cnt != ll0 || res_q.size() != 0)
      $display("FAIL rw_abandon: learns=%0d results=%0d want 0/0", ll_cnt - ll0, res_q.size());
    else passed++;
    test_single(40, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_in     = '0;
    bus.s_target = '0;
    bus.learn_en = 1'b0;
    bus.r_ready  = 1'b0;
    test_reset();
    test_single(1, 1'b1);
    test_single(2, 1'b0);
    test_fill();
    test_backpressure();
    test_reset_wait();
    checks++;
    if (both_cnt != 0) $display("FAIL valid_learn_overlap: got %0d want 0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
